// File: rtl/dot_score_pkg.sv
// Shared types and constants for the dot score keeper.
//   state_e      : PLAY / CLEAR_WAIT / RELOAD sequencing states
//   DOTS_PER_ROW : dots in each monitored row
//   bcd4_t       : four packed BCD digits, [3] = thousands ... [0] = ones
//   SCORE_MAX    : saturation value of the score
//   bcd_add_ten  : adds 10 points (one tens-digit step) with ripple carry
package dot_score_pkg;

    typedef enum logic [1:0] {
        PLAY,
        CLEAR_WAIT,
        RELOAD
    } state_e;

    localparam int unsigned DOTS_PER_ROW = 12;

    typedef logic [3:0][3:0] bcd4_t;

    localparam bcd4_t SCORE_MAX = 16'h9990;

    // The ones digit is never touched; the caller guarantees the value is
    // below SCORE_MAX so the thousands digit cannot overflow.
    function automatic bcd4_t bcd_add_ten(input bcd4_t s);
        bcd4_t r;
        logic  carry;
        r     = s;
        carry = 1'b1;
        for (int d = 1; d < 4; d++) begin
            if (carry) begin
                if (r[d] == 4'd9) begin
                    r[d] = 4'd0;
                end else begin
                    r[d]  = r[d] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_score_keeper_if.sv
// Bundle between the dot-row array and the score keeper.
//   stillHere  : NUM_ROWS*12 dot-present bits, row r at [r*12+11 : r*12]
//   anyLeft    : per-row any-dot-present flags
//   score      : 4-digit BCD score
//   level      : levels cleared (binary, saturating)
//   levelClear : one-cycle pulse on board clear
//   rowReset   : reload strobe to the dot rows
//   gameActive : high while playing
// master = dot-row side (drives dots), slave = score keeper.
interface dot_score_keeper_if #(
    parameter int unsigned NUM_ROWS = 8
);
    logic [NUM_ROWS*dot_score_pkg::DOTS_PER_ROW-1:0] stillHere;
    logic [NUM_ROWS-1:0]                             anyLeft;
    logic [15:0]                                     score;
    logic [3:0]                                      level;
    logic                                            levelClear;
    logic                                            rowReset;
    logic                                            gameActive;

    modport master (
        output stillHere, anyLeft,
        input  score, level, levelClear, rowReset, gameActive
    );

    modport slave (
        input  stillHere, anyLeft,
        output score, level, levelClear, rowReset, gameActive
    );
endinterface

// File: rtl/dot_popcount.sv
// Combinational population count of a bit vector.
//   vec_i   : WIDTH-bit input vector
//   count_o : number of set bits (7 bits, WIDTH must not exceed 127)
module dot_popcount #(
    parameter int unsigned WIDTH = 96
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [6:0]       count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            count_o = count_o + {6'b0, vec_i[i]};
        end
    end

endmodule

// File: rtl/dot_score_keeper.sv
// Score keeper for the dot-row array. Turns every dot disappearance into a
// 10-point BCD score step, detects board clear, and sequences the reload.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of dot_score_keeper_if (dot inputs, score/level/
//           levelClear/rowReset/gameActive outputs)
module dot_score_keeper
    import dot_score_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned CLEAR_HOLD = 60
) (
    input logic               clk,
    input logic               reset,
    dot_score_keeper_if.slave bus
);

    localparam int unsigned NumDots = NUM_ROWS * DOTS_PER_ROW;
    localparam int unsigned HoldW   = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;

    state_e             state_q, state_d;
    logic [NumDots-1:0] prev_here_q;
    logic [NumDots-1:0] fall_vec;
    logic [6:0]         falls;
    logic [6:0]         pending_q, pending_d;
    bcd4_t              score_q, score_d;
    logic [3:0]         level_q, level_d;
    logic               level_clear_q, level_clear_d;
    logic               seen_dot_q, seen_dot_d;
    logic [HoldW-1:0]   hold_q, hold_d;

    // Only present-to-absent transitions score; reloaded dots rising are ignored.
    assign fall_vec = prev_here_q & ~bus.stillHere;

    dot_popcount #(
        .WIDTH (NumDots)
    ) u_popcount (
        .vec_i   (fall_vec),
        .count_o (falls)
    );

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        level_d       = level_q;
        seen_dot_d    = seen_dot_q;
        hold_d        = hold_q;
        level_clear_d = 1'b0;

        // Drain one point per cycle in every state; new falls only count in PLAY.
        pending_d = pending_q - {6'b0, (pending_q != '0)};
        if (state_q == PLAY) begin
            pending_d = pending_d + falls;
        end

        if ((pending_q != '0) && (score_q != SCORE_MAX)) begin
            score_d = bcd_add_ten(score_q);
        end

        if ((state_q == PLAY) && (|bus.stillHere)) begin
            seen_dot_d = 1'b1;
        end

        unique case (state_q)
            PLAY: begin
                // A drop visible this cycle still has to be scored before the
                // board counts as cleared.
                if (!(|bus.anyLeft) && (pending_q == '0) && (falls == '0) && seen_dot_q) begin
                    state_d       = CLEAR_WAIT;
                    level_clear_d = 1'b1;
                    hold_d        = HoldW'(CLEAR_HOLD - 1);
                    if (level_q != 4'd15) begin
                        level_d = level_q + 4'd1;
                    end
                end
            end
            CLEAR_WAIT: begin
                if (hold_q == '0) begin
                    state_d    = RELOAD;
                    seen_dot_d = 1'b0;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            RELOAD: begin
                state_d = PLAY;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= PLAY;
            prev_here_q   <= '0;
            pending_q     <= '0;
            score_q       <= '0;
            level_q       <= '0;
            level_clear_q <= 1'b0;
            seen_dot_q    <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            prev_here_q   <= bus.stillHere;
            pending_q     <= pending_d;
            score_q       <= score_d;
            level_q       <= level_d;
            level_clear_q <= level_clear_d;
            seen_dot_q    <= seen_dot_d;
            hold_q        <= hold_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.level      = level_q;
    assign bus.levelClear = level_clear_q;
    assign bus.rowReset   = (state_q == RELOAD);
    assign bus.gameActive = (state_q == PLAY);

endmodule

// File: tb/tb_dot_score_keeper.sv
// Self-checking bench for dot_score_keeper: randomized dot activity checked
// every cycle against a points/pending/clear-timer model, plus literal
// expectations for the key scenarios.
module tb_dot_score_keeper;

    localparam int unsigned NR   = 8;
    localparam int unsigned ND   = NR * 12;
    localparam int unsigned HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_score_keeper_if #(.NUM_ROWS(NR)) bus ();

    dot_score_keeper #(
        .NUM_ROWS   (NR),
        .CLEAR_HOLD (HOLD)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] rows_any(input logic [ND-1:0] v);
        logic [NR-1:0] res;
        for (int r = 0; r < int'(NR); r++) begin
            res[r] = |v[r*12 +: 12];
        end
        return res;
    endfunction

    task automatic set_board(input logic [ND-1:0] v);
        bus.stillHere = v;
        bus.anyLeft   = rows_any(v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int p);
        return {4'(p / 1000), 4'((p / 100) % 10), 4'((p / 10) % 10), 4'(p % 10)};
    endfunction

    // Model: score in plain points, a backlog of unscored drops, and the
    // number of edges since the last board clear (-1 while playing).
    logic [ND-1:0] m_prev  = '0;
    int            m_pend  = 0;
    int            m_pts   = 0;
    int            m_level = 0;
    int            m_since = -1;
    bit            m_seen  = 1'b0;
    int            mf;
    bit            m_play, m_clr, m_seen_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev  = '0;
            m_pend  = 0;
            m_pts   = 0;
            m_level = 0;
            m_since = -1;
            m_seen  = 1'b0;
        end else begin
            mf     = $countones(m_prev & ~bus.stillHere);
            m_play = (m_since < 0);
            m_clr  = m_play && (bus.anyLeft == '0) && (m_pend == 0) && (mf == 0) && m_seen;
            if (m_pend > 0 && m_pts < 9990) m_pts += 10;
            if (m_pend > 0) m_pend--;
            if (m_play) m_pend += mf;
            m_seen_n = m_seen || (m_play && (|bus.stillHere));
            if (m_clr) begin
                m_since = 0;
                if (m_level < 15) m_level++;
            end else if (m_since >= 0) begin
                m_since++;
                if (m_since == int'(HOLD)) m_seen_n = 1'b0;
                if (m_since > int'(HOLD)) m_since = -1;
            end
            m_seen = m_seen_n;
            m_prev = bus.stillHere;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("score", bus.score, to_bcd(m_pts));
        chk("level", bus.level, 4'(m_level));
        chk("levelClear", bus.levelClear, m_since == 0);
        chk("rowReset", bus.rowReset, m_since == int'(HOLD));
        chk("gameActive", bus.gameActive, m_since < 0);
    end

    int lc_count = 0;
    int rr_count = 0;
    always @(negedge clk) begin
        if (bus.levelClear === 1'b1) lc_count++;
        if (bus.rowReset === 1'b1) rr_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    logic [ND-1:0] all_ones;
    logic [ND-1:0] v;
    int            n;
    int            rr_before;
    int            lc_before;

    initial begin
        all_ones = '1;
        set_board('0);
        step(3);
        @(negedge clk);
        chk("reset_score", bus.score, 16'h0000);
        chk("reset_level", bus.level, 4'd0);
        chk("reset_gameActive", bus.gameActive, 1'b1);
        chk("reset_rowReset", bus.rowReset, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Board never populated: no clear may fire.
        step(40);
        chk("no_clear_unpopulated", lc_count, 0);

        // Single drop in row 0.
        set_board(all_ones);
        step(2);
        v = all_ones;
        v[0] = 1'b0;
        set_board(v);
        step(2);
        chk("one_drop_score", bus.score, 16'h0010);
        chk("one_drop_level", bus.level, 4'd0);

        // Three simultaneous drops across rows 2 and 5.
        v[2*12+3]  = 1'b0;
        v[5*12+0]  = 1'b0;
        v[5*12+11] = 1'b0;
        set_board(v);
        step(2);
        chk("three_drop_a", bus.score, 16'h0020);
        step(1);
        chk("three_drop_b", bus.score, 16'h0030);
        step(1);
        chk("three_drop_c", bus.score, 16'h0040);

        // Random drops, restores and bursts; one dot is kept to block a clear.
        for (int i = 0; i < 300; i++) begin
            v = bus.stillHere;
            case ($urandom_range(0, 3))
                0: v[$urandom_range(0, ND - 1)] = 1'b0;
                1: v[$urandom_range(0, ND - 1)] = 1'b1;
                2: if (m_pend < 20) v = v & ~({$urandom, $urandom, $urandom}
                                              & {$urandom, $urandom, $urandom}
                                              & {$urandom, $urandom, $urandom});
                default: ;
            endcase
            v[ND-1] = 1'b1;
            set_board(v);
            step(1);
        end

        // Board clear: refill, leave one dot, then remove it.
        set_board(all_ones);
        step(2);
        v = '0;
        v[0] = 1'b1;
        set_board(v);
        step(2);
        chk("no_clear_one_left", bus.gameActive, 1'b1);
        set_board('0);
        n = 0;
        while (bus.levelClear !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("levelClear_seen", n < 400, 1'b1);
        chk("clear_level", bus.level, 4'd1);
        chk("clear_gameActive", bus.gameActive, 1'b0);
        n = 0;
        while (bus.rowReset !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rowReset_delay", n, HOLD);
        @(posedge clk);
        #1 set_board(all_ones);
        @(negedge clk);
        chk("rowReset_one_cycle", bus.rowReset, 1'b0);
        chk("back_to_play", bus.gameActive, 1'b1);
        step(5);
        chk("single_clear_pulse", lc_count, 1);

        // Saturation: 999 more drops of one dot.
        for (int i = 0; i < 999; i++) begin
            v = all_ones;
            v[5] = 1'b0;
            set_board(v);
            step(1);
            set_board(all_ones);
            step(1);
        end
        step(3);
        chk("saturated_score", bus.score, 16'h9990);

        // Second clear, then reset in the middle of CLEAR_WAIT.
        set_board('0);
        n = 0;
        while (bus.levelClear !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("levelClear2_seen", n < 400, 1'b1);
        chk("clear2_level", bus.level, 4'd2);
        @(negedge clk);
        @(negedge clk);
        rr_before = rr_count;
        #1 rst = 1'b1;
        #1;
        chk("midreset_score", bus.score, 16'h0000);
        chk("midreset_level", bus.level, 4'd0);
        chk("midreset_gameActive", bus.gameActive, 1'b1);
        chk("midreset_rowReset", bus.rowReset, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        lc_before = lc_count;
        step(20);
        chk("no_rowReset_after_reset", rr_count, rr_before);
        chk("no_clear_after_reset", lc_count, lc_before);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
